// File: rtl/spi_arbiter.sv
// Two-requester round-robin arbiter in front of one SPI serdes, one transaction in flight at a time.
// Optional watchdog: define SPI_ARB_TIMEOUT_EN to abort transfers that see no done within TIMEOUT_CYCLES.
module spi_arbiter #(
    parameter int CMD_WIDTH      = 16,
    parameter int RX_WIDTH       = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 spi_clk,
    input  logic                 reset_n,
    input  logic                 req0,
    input  logic                 req1,
    input  logic [CMD_WIDTH-1:0] cmd0,
    input  logic [CMD_WIDTH-1:0] cmd1,
    output logic                 ack0,
    output logic                 ack1,
    output logic [RX_WIDTH-1:0]  rdata,
    output logic                 err,
    output logic                 busy,
    output logic [CMD_WIDTH-1:0] data_tx,
    output logic                 start,
    input  logic                 done,
    input  logic [RX_WIDTH-1:0]  data_rx
);
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        GAP  = 2'b10
    } state_t;

    state_t               state_r;
    state_t               state_s;
    logic                 start_r;
    logic                 start_s;
    logic [CMD_WIDTH-1:0] data_tx_r;
    logic [CMD_WIDTH-1:0] data_tx_s;
    logic [RX_WIDTH-1:0]  rdata_r;
    logic [RX_WIDTH-1:0]  rdata_s;
    logic                 ack0_r;
    logic                 ack0_s;
    logic                 ack1_r;
    logic                 ack1_s;
    logic                 grant_r;
    logic                 grant_s;
    logic                 last_r;
    logic                 last_s;
    logic                 pick_s;
    logic                 timeout_hit_s;

    // On a tie the port that was not served last wins; otherwise the lone requester wins.
    assign pick_s = (req0 && req1) ? ~last_r : req1;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic             err_r;

    assign timeout_hit_s = (state_r == BUSY) && !done &&
                           (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));

    // Watchdog count: advances only while staying in BUSY, zero otherwise.
    always_comb begin
        cnt_s = {CNT_W{1'b0}};
        if ((state_r == BUSY) && (state_s == BUSY)) begin
            cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_s = {CNT_W{1'b0}};
        end
    end

    // Watchdog counter and error flag registers.
    always_ff @(posedge spi_clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r <= {CNT_W{1'b0}};
            err_r <= 1'b0;
        end else begin
            cnt_r <= cnt_s;
            err_r <= timeout_hit_s;
        end
    end

    assign err = err_r;
`else
    logic cfg_unused_s;

    assign cfg_unused_s  = (TIMEOUT_CYCLES > 0);
    assign timeout_hit_s = 1'b0;
    assign err           = 1'b0;
`endif

    // Next-state and next-output logic for the IDLE/BUSY/GAP sequencer.
    always_comb begin
        state_s   = state_r;
        start_s   = start_r;
        data_tx_s = data_tx_r;
        rdata_s   = rdata_r;
        grant_s   = grant_r;
        last_s    = last_r;
        ack0_s    = 1'b0;
        ack1_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (req0 || req1) begin
                    grant_s   = pick_s;
                    last_s    = pick_s;
                    data_tx_s = pick_s ? cmd1 : cmd0;
                    start_s   = 1'b1;
                    state_s   = BUSY;
                end else begin
                    start_s   = 1'b0;
                end
            end
            BUSY: begin
                if (done || timeout_hit_s) begin
                    start_s = 1'b0;
                    rdata_s = done ? data_rx : {RX_WIDTH{1'b1}};
                    ack0_s  = ~grant_r;
                    ack1_s  = grant_r;
                    state_s = GAP;
                end else begin
                    start_s = 1'b1;
                end
            end
            // Wait for the serdes to drop done before a new grant can be issued.
            GAP: begin
                if (!done) begin
                    state_s = IDLE;
                end else begin
                    state_s = GAP;
                end
            end
            default: begin
                state_s = IDLE;
                start_s = 1'b0;
            end
        endcase
    end

    // State and registered output flops.
    always_ff @(posedge spi_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= IDLE;
            start_r   <= 1'b0;
            data_tx_r <= {CMD_WIDTH{1'b0}};
            rdata_r   <= {RX_WIDTH{1'b0}};
            ack0_r    <= 1'b0;
            ack1_r    <= 1'b0;
            grant_r   <= 1'b0;
            last_r    <= 1'b1;
        end else begin
            state_r   <= state_s;
            start_r   <= start_s;
            data_tx_r <= data_tx_s;
            rdata_r   <= rdata_s;
            ack0_r    <= ack0_s;
            ack1_r    <= ack1_s;
            grant_r   <= grant_s;
            last_r    <= last_s;
        end
    end

    assign start   = start_r;
    assign data_tx = data_tx_r;
    assign rdata   = rdata_r;
    assign ack0    = ack0_r;
    assign ack1    = ack1_r;
    assign busy    = (state_r != IDLE);

endmodule

// File: tb/tb_spi_arbiter.sv
// Self-checking bench for spi_arbiter: directed scenarios plus randomized traffic against a round-robin model.
// Build with SPI_ARB_TIMEOUT_EN defined to exercise the watchdog path.
module tb_spi_arbiter;
    logic        spi_clk = 1'b0;
    logic        reset_n;
    logic        req0;
    logic        req1;
    logic [15:0] cmd0;
    logic [15:0] cmd1;
    logic        ack0;
    logic        ack1;
    logic [7:0]  rdata;
    logic        err;
    logic        busy;
    logic [15:0] data_tx;
    logic        start;
    logic        done;
    logic [7:0]  data_rx;

    int n_cmp = 0;
    int n_bad = 0;
    int last_model = 1;

    bit          obs_started;
    int          obs_wait;
    logic [15:0] obs_tx;
    bit          obs_hold_bad;
    bit          obs_ack_early;
    bit          obs_stuck;
    logic        obs_a0;
    logic        obs_a1;
    logic        obs_start_ack;
    logic        obs_err_ack;
    logic        obs_busy_ack;
    logic        obs_busy_after;
    logic [7:0]  obs_rd;

    spi_arbiter #(
        .CMD_WIDTH(16),
        .RX_WIDTH(8),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .spi_clk(spi_clk),
        .reset_n(reset_n),
        .req0(req0),
        .req1(req1),
        .cmd0(cmd0),
        .cmd1(cmd1),
        .ack0(ack0),
        .ack1(ack1),
        .rdata(rdata),
        .err(err),
        .busy(busy),
        .data_tx(data_tx),
        .start(start),
        .done(done),
        .data_rx(data_rx)
    );

    always #5 spi_clk = ~spi_clk;

    // Plays the serdes for one transaction: waits for start, holds done low for lat cycles, then completes.
    task automatic serve(input int lat, input logic [7:0] rx_byte, input bit mutate, input bit release_winner);
        obs_started = 0; obs_wait = 0; obs_tx = 16'h0000; obs_hold_bad = 0; obs_ack_early = 0;
        obs_stuck = 0; obs_a0 = 1'b0; obs_a1 = 1'b0; obs_start_ack = 1'b0; obs_err_ack = 1'b0;
        obs_busy_ack = 1'b0; obs_busy_after = 1'b0; obs_rd = 8'h00;
        for (int i = 1; i <= 8 && !obs_started; i++) begin
            @(negedge spi_clk);
            if (ack0 || ack1) obs_ack_early = 1;
            if (start) begin
                obs_started = 1;
                obs_wait    = i;
                obs_tx      = data_tx;
            end
        end
        if (obs_started) begin
            for (int i = 0; i < lat; i++) begin
                if (mutate) begin
                    cmd0 = 16'($urandom);
                    cmd1 = 16'($urandom);
                end
                @(negedge spi_clk);
                if (!start || data_tx !== obs_tx || ack0 || ack1) obs_hold_bad = 1;
            end
            done    = 1'b1;
            data_rx = rx_byte;
            @(negedge spi_clk);
            obs_a0 = ack0; obs_a1 = ack1; obs_rd = rdata;
            obs_start_ack = start; obs_err_ack = err; obs_busy_ack = busy;
            done    = 1'b0;
            data_rx = 8'($urandom);
            if (release_winner) begin
                if (ack0) req0 = 1'b0;
                if (ack1) req1 = 1'b0;
            end
            @(negedge spi_clk);
            obs_stuck      = ack0 || ack1;
            obs_busy_after = busy;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge spi_clk);
        reset_n = 1'b1;
        last_model = 1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; req0 = 1'b0; req1 = 1'b0; cmd0 = 16'h0000; cmd1 = 16'h0000;
        done = 1'b0; data_rx = 8'h00;
        @(negedge spi_clk);
        n_cmp++;
        if ({start, data_tx, ack0, ack1, err, rdata, busy} !== 29'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got start=%b tx=%h ack=%b%b err=%b rdata=%h busy=%b, want all zero",
                     start, data_tx, ack0, ack1, err, rdata, busy);
        end
        @(negedge spi_clk);
        reset_n = 1'b1;
        last_model = 1;
    endtask

    task automatic test_single();
        req0 = 1'b1; req1 = 1'b0; cmd0 = 16'h2D08;
        serve(20, 8'h00, 0, 1);
        n_cmp++;
        if (!obs_started || obs_wait != 1) begin
            n_bad++; $display("FAIL single_latency: start after %0d cycles (seen=%0d), want 1", obs_wait, obs_started);
        end
        n_cmp++;
        if (obs_tx !== 16'h2D08) begin
            n_bad++; $display("FAIL single_data_tx: got %h, want 2d08", obs_tx);
        end
        n_cmp++;
        if (obs_hold_bad) begin
            n_bad++; $display("FAIL single_hold: start/data_tx disturbed or early ack, got 1 want 0");
        end
        n_cmp++;
        if ({obs_a0, obs_a1, obs_rd, obs_start_ack} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
            n_bad++; $display("FAIL single_ack: got ack0=%b ack1=%b rdata=%h start=%b, want 1 0 00 0",
                              obs_a0, obs_a1, obs_rd, obs_start_ack);
        end
        n_cmp++;
        if (obs_stuck) begin
            n_bad++; $display("FAIL single_ack_pulse: ack still high a cycle later, want one-cycle pulse");
        end
        last_model = 0;
    endtask

    task automatic test_round_robin();
        int exp_port;
        logic [7:0] b;
        do_reset();
        req0 = 1'b1; req1 = 1'b1; cmd0 = 16'($urandom); cmd1 = 16'($urandom);
        for (int t = 0; t < 4; t++) begin
            exp_port = 1 - last_model;
            b = 8'($urandom);
            serve(int'($urandom_range(0, 4)), b, 0, 0);
            n_cmp++;
            if (!obs_started || obs_ack_early || obs_a0 !== (exp_port == 0) || obs_a1 !== (exp_port == 1)) begin
                n_bad++; $display("FAIL rr_grant[%0d]: got ack0=%b ack1=%b, want port %0d", t, obs_a0, obs_a1, exp_port);
            end
            n_cmp++;
            if (obs_tx !== (exp_port == 1 ? cmd1 : cmd0) || obs_rd !== b || obs_stuck) begin
                n_bad++; $display("FAIL rr_data[%0d]: got tx=%h rdata=%h, want tx=%h rdata=%h",
                                  t, obs_tx, obs_rd, (exp_port == 1 ? cmd1 : cmd0), b);
            end
            last_model = exp_port;
        end
        req0 = 1'b0; req1 = 1'b0;
    endtask

    task automatic test_req1_only();
        req0 = 1'b0; req1 = 1'b1; cmd1 = 16'($urandom);
        for (int t = 0; t < 3; t++) begin
            serve(int'($urandom_range(0, 3)), 8'($urandom), 0, 0);
            n_cmp++;
            if (!obs_started || {obs_a0, obs_a1} !== 2'b01) begin
                n_bad++; $display("FAIL req1_only_ack[%0d]: got ack0=%b ack1=%b, want 0 1", t, obs_a0, obs_a1);
            end
            n_cmp++;
            if (obs_busy_ack !== 1'b1 || obs_busy_after !== 1'b0) begin
                n_bad++; $display("FAIL req1_only_gap[%0d]: busy in gap=%b then=%b, want 1 then 0",
                                  t, obs_busy_ack, obs_busy_after);
            end
        end
        req1 = 1'b0;
        last_model = 1;
    endtask

    task automatic test_cmd_change();
        logic [15:0] latched;
        req0 = 1'b0; req1 = 1'b1; cmd1 = 16'($urandom);
        latched = cmd1;
        serve(6, 8'($urandom), 1, 1);
        n_cmp++;
        if (obs_tx !== latched || obs_hold_bad || obs_a1 !== 1'b1) begin
            n_bad++; $display("FAIL cmd_change: got tx=%h hold_bad=%0d ack1=%b, want tx=%h 0 1",
                              obs_tx, obs_hold_bad, obs_a1, latched);
        end
        last_model = 1;
    endtask

    task automatic test_reset_mid();
        bit got;
        bit bad;
        logic [7:0] b;
        req0 = 1'b1; req1 = 1'b0; cmd0 = 16'($urandom);
        got = 0;
        for (int i = 0; i < 4 && !got; i++) begin
            @(negedge spi_clk);
            if (start) got = 1;
        end
        n_cmp++;
        if (!got) begin
            n_bad++; $display("FAIL reset_mid_start: start never rose, want 1");
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (start !== 1'b0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL reset_mid_async: start=%b busy=%b during reset, want 0 0", start, busy);
        end
        req0 = 1'b0;
        @(negedge spi_clk);
        reset_n = 1'b1;
        last_model = 1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge spi_clk);
            if (ack0 || ack1 || start) bad = 1;
        end
        n_cmp++;
        if (bad) begin
            n_bad++; $display("FAIL reset_mid_no_ack: ack or start seen after abort, want none");
        end
        req0 = 1'b1; req1 = 1'b1; cmd0 = 16'($urandom); cmd1 = 16'($urandom);
        b = 8'($urandom);
        serve(2, b, 0, 0);
        n_cmp++;
        if (!obs_started || {obs_a0, obs_a1} !== 2'b10 || obs_tx !== cmd0 || obs_rd !== b) begin
            n_bad++; $display("FAIL reset_mid_regrant: got ack=%b%b tx=%h rdata=%h, want 10 %h %h",
                              obs_a0, obs_a1, obs_tx, obs_rd, cmd0, b);
        end
        req0 = 1'b0; req1 = 1'b0;
        last_model = 0;
    endtask

    task automatic test_timeout();
        bit got;
        bit bad;
        req0 = 1'b1; req1 = 1'b0; cmd0 = 16'($urandom);
        got = 0;
        for (int i = 0; i < 4 && !got; i++) begin
            @(negedge spi_clk);
            if (start) got = 1;
        end
        n_cmp++;
        if (!got) begin
            n_bad++; $display("FAIL timeout_start: start never rose, want 1");
        end
        bad = 0;
`ifdef SPI_ARB_TIMEOUT_EN
        for (int k = 1; k < 16; k++) begin
            @(negedge spi_clk);
            if (ack0 || ack1 || err || !start) bad = 1;
        end
        n_cmp++;
        if (bad) begin
            n_bad++; $display("FAIL timeout_early: ack/err or start drop before 16 cycles, want none");
        end
        @(negedge spi_clk);
        n_cmp++;
        if ({ack0, ack1, err, start, rdata} !== {1'b1, 1'b0, 1'b1, 1'b0, 8'hFF}) begin
            n_bad++; $display("FAIL timeout_abort: got ack0=%b ack1=%b err=%b start=%b rdata=%h, want 1 0 1 0 ff",
                              ack0, ack1, err, start, rdata);
        end
        req0 = 1'b0;
        @(negedge spi_clk);
        n_cmp++;
        if (ack0 || err) begin
            n_bad++; $display("FAIL timeout_pulse: ack0=%b err=%b a cycle later, want 0 0", ack0, err);
        end
`else
        for (int k = 0; k < 40; k++) begin
            @(negedge spi_clk);
            if (ack0 || ack1 || err || !start || !busy) bad = 1;
        end
        n_cmp++;
        if (bad) begin
            n_bad++; $display("FAIL no_timeout_wait: left BUSY without done, want to stay");
        end
        done = 1'b1; data_rx = 8'h5A;
        @(negedge spi_clk);
        n_cmp++;
        if ({ack0, err, rdata} !== {1'b1, 1'b0, 8'h5A}) begin
            n_bad++; $display("FAIL no_timeout_finish: got ack0=%b err=%b rdata=%h, want 1 0 5a", ack0, err, rdata);
        end
        done = 1'b0; req0 = 1'b0;
        @(negedge spi_clk);
`endif
        last_model = 0;
    endtask

    task automatic test_random();
        int exp_port;
        logic [15:0] exp_tx;
        logic [7:0] b;
        for (int it = 0; it < 40; it++) begin
            if (!req0 && $urandom_range(0, 1) == 1) begin req0 = 1'b1; cmd0 = 16'($urandom); end
            if (!req1 && $urandom_range(0, 1) == 1) begin req1 = 1'b1; cmd1 = 16'($urandom); end
            if (!req0 && !req1) begin
                if ($urandom_range(0, 1) == 1) begin req0 = 1'b1; cmd0 = 16'($urandom); end
                else begin req1 = 1'b1; cmd1 = 16'($urandom); end
            end
            exp_port = (req0 && req1) ? 1 - last_model : (req1 ? 1 : 0);
            exp_tx   = (exp_port == 1) ? cmd1 : cmd0;
            b        = 8'($urandom);
            serve(int'($urandom_range(0, 5)), b, 0, 1'($urandom_range(0, 1)));
            n_cmp++;
            if (!obs_started || obs_ack_early || obs_hold_bad || obs_stuck ||
                obs_a0 !== (exp_port == 0) || obs_a1 !== (exp_port == 1)) begin
                n_bad++; $display("FAIL random_grant[%0d]: got ack0=%b ack1=%b started=%0d, want port %0d",
                                  it, obs_a0, obs_a1, obs_started, exp_port);
            end
            n_cmp++;
            if (obs_tx !== exp_tx || obs_rd !== b || obs_err_ack !== 1'b0 || obs_start_ack !== 1'b0) begin
                n_bad++; $display("FAIL random_data[%0d]: got tx=%h rdata=%h err=%b, want tx=%h rdata=%h err=0",
                                  it, obs_tx, obs_rd, obs_err_ack, exp_tx, b);
            end
            last_model = exp_port;
        end
        req0 = 1'b0; req1 = 1'b0;
        @(negedge spi_clk);
    endtask

    // Scenario sequence.
    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_req1_only();
        test_cmd_change();
        test_reset_mid();
        test_timeout();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_arbiter.md
SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 SHALL have parameter CMD_WIDTH, default 16, meaning the width of the serdes transmit word.
REQ-002 SHALL have parameter RX_WIDTH, default 8, meaning the width of the serdes receive byte.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning the watchdog limit in spi_clk cycles, used only under SPI_ARB_TIMEOUT_EN.
REQ-004 SHALL have port spi_clk, input, 1, the clock for all logic.
REQ-005 SHALL have port reset_n, input, 1, reset, asynchronous and active-low.
REQ-006 SHALL have ports req0/req1, input, 1 each, level transaction request from requester 0/1.
REQ-007 SHALL have ports cmd0/cmd1, input, CMD_WIDTH each, command word, held stable while the matching req is high.
REQ-008 SHALL have ports ack0/ack1, output, 1 each, one-cycle completion pulse to requester 0/1.
REQ-009 SHALL have port rdata, output, RX_WIDTH, received byte, valid in the ack cycle and held until the next ack.
REQ-010 SHALL have port err, output, 1, timeout flag, pulsed together with ack.
REQ-011 SHALL have port busy, output, 1, high whenever the state is not IDLE.
REQ-012 SHALL have port data_tx, output, CMD_WIDTH, command word to the serdes.
REQ-013 SHALL have port start, output, 1, serdes start level.
REQ-014 SHALL have port done, input, 1, serdes completion level, high until start falls.
REQ-015 SHALL have port data_rx, input, RX_WIDTH, serdes received byte, valid while done is high.

Function
REQ-016 SHALL implement a 3-state FSM with states IDLE, BUSY and GAP; any unreachable encoding SHALL go to IDLE.
REQ-017 In IDLE with any req high, the block SHALL select a port, register grant, load data_tx from the selected port's cmd, set start=1 and enter BUSY on the next edge, giving one cycle of latency from req to start.
REQ-018 Arbitration SHALL be round-robin: with one req high, that port wins; with both high, the port not served last wins; last_served SHALL update on every grant.
REQ-019 In BUSY, start and data_tx SHALL be held constant; when done=1 the block SHALL clear start, capture rdata<=data_rx, pulse ack of the granted port for exactly one cycle, and enter GAP.
REQ-020 In GAP, the block SHALL return to IDLE on the first cycle in which done=0; req SHALL be ignored while in GAP.
REQ-021 A requester that holds req high through its ack SHALL be treated as issuing a new request; back-to-back grants SHALL still alternate when both ports are requesting.
REQ-022 ack0 and ack1 SHALL never be high in the same cycle; at most one transaction SHALL be outstanding.
REQ-023 A change in req or cmd while the state is BUSY SHALL have no effect on the in-flight transaction.
REQ-024 done=1 observed in IDLE SHALL be ignored.

Reset
REQ-025 While reset_n=0, the block SHALL be in IDLE with start=0, data_tx=0, ack0=ack1=0, err=0, rdata=0, busy=0, last_served=1 (port 0 wins the first tie), and the timeout counter at 0.
REQ-026 Reset asserted mid-transaction SHALL drop start immediately (asynchronously), and no ack SHALL be issued for the aborted transaction.

Configuration
REQ-027 With macro SPI_ARB_TIMEOUT_EN defined, a counter SHALL run in BUSY; when it reaches TIMEOUT_CYCLES-1 without done, the block SHALL clear start, set rdata to all-ones, pulse ack of the granted port together with err for one cycle, and enter GAP; the counter SHALL clear on leaving BUSY.
REQ-028 With SPI_ARB_TIMEOUT_EN undefined, there SHALL be no counter, err SHALL be tied to 0, and BUSY SHALL wait for done indefinitely.

Verification
REQ-029 req0=1, cmd0=16'h2D08, serdes returns done after 20 cycles with data_rx=8'h00 -> start rises 1 cycle after req0, data_tx=16'h2D08, then a single ack0 pulse and rdata=8'h00.
REQ-030 req0=req1=1 from reset, both held for 4 transactions -> grant order 0,1,0,1; ack0/ack1 are never simultaneous.
REQ-031 Only req1 held high for 3 transactions -> three ack1 pulses, each separated by at least one GAP cycle and one IDLE cycle.
REQ-032 cmd1 changed during BUSY -> data_tx keeps the latched value until ack1.
REQ-033 reset_n pulsed low while BUSY -> start=0 asynchronously, no ack, and after release the next request is granted normally.
REQ-034 With SPI_ARB_TIMEOUT_EN defined and TIMEOUT_CYCLES=16, done held at 0 -> ack0 and err high together 16 cycles after start rose, rdata=8'hFF, start=0; without the macro, the block stays in BUSY.
